// File: rtl/ms_pipe_pkg.sv
// Shared types and helpers for the elastic valid/ready pipeline.
// Holds the per-stage state encoding and the occupancy width helper.
package ms_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKID
  } stage_state_t;

  // Counter must represent 0..2*depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/ms_skid_stage.sv
// One elastic stage: a main register plus a skid register.
// Upstream ready is registered (derived from state only), so stages chain without combinational ready paths.
module ms_skid_stage
  import ms_pipe_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_DATA = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  stage_state_t     state;
  stage_state_t     state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             up_fire;
  logic             down_fire;

  assign in_ready  = (state != ST_SKID);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign up_fire   = in_valid & in_ready;
  assign down_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_EMPTY;
      main_q <= RESET_DATA;
      skid_q <= RESET_DATA;
    end else begin
      state  <= state_next;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    state_next = state;
    main_d     = main_q;
    skid_d     = skid_q;
    case (state)
      ST_EMPTY: begin
        if (up_fire) begin
          state_next = ST_FULL;
          main_d     = in_data;
        end
      end
      ST_FULL: begin
        if (up_fire && down_fire) begin
          main_d = in_data;
        end else if (up_fire) begin
          state_next = ST_SKID;
          skid_d     = in_data;
        end else if (down_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (down_fire) begin
          state_next = ST_FULL;
          main_d     = skid_q;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    // Flush only drops validity; data registers keep whatever they held.
    if (flush) begin
      state_next = ST_EMPTY;
      main_d     = main_q;
      skid_d     = skid_q;
    end
  end

endmodule

// File: rtl/ms_elastic_pipe.sv
// Multi-stage elastic pipeline: a chain of DEPTH skid stages with an occupancy counter.
// Capacity is 2*DEPTH words; latency is DEPTH cycles when not stalled.
module ms_elastic_pipe
  import ms_pipe_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_DATA = '1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int OW = occ_width(DEPTH);

  logic [DEPTH:0]   stage_valid;
  logic [DEPTH:0]   stage_ready;
  logic [WIDTH-1:0] stage_data [DEPTH+1];
  logic             in_fire;
  logic             out_fire;

  assign stage_valid[0]     = in_valid;
  assign stage_data[0]      = in_data;
  assign stage_ready[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    ms_skid_stage #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (stage_valid[i]),
      .in_ready  (stage_ready[i]),
      .in_data   (stage_data[i]),
      .out_valid (stage_valid[i+1]),
      .out_ready (stage_ready[i+1]),
      .out_data  (stage_data[i+1])
    );
  end

  // Stage state is not yet cleared during the first reset cycle, so gate ready with reset.
  assign in_ready  = stage_ready[0] & ~reset;
  assign out_valid = stage_valid[DEPTH];
  assign out_data  = stage_data[DEPTH];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + OW'(1);
    end else if (!in_fire && out_fire) begin
      occupancy <= occupancy - OW'(1);
    end
  end

endmodule
